cipu_gen: RTL and testbench

CIPU_GEN -- requirements
Module: cipu_gen

---
 rtl/cipu_gen.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cipu_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipu_gen.sv
// Purpose: two independent character channels. The queue channel filters
//          letters into a FIFO and emits them. The stack channel pushes
//          characters, pops groups on a separator and drains oldest-first
//          on the end code.
// Latency: an entry pushed at edge N is emitted no earlier than edge N+1.
//          Stack pops start one cycle after the separator is accepted.
// Backpressure: none on the outputs. The stack source holds the separator
//          until it sees done_thing.
// Ports:
//   clk, rst (sync, active-low)          clock and reset
//   ready_fifo / ready_lifo              start strobes per channel
//   people_thing_in -> people_thing_out  queue channel, qualified by valid_fifo
//   thing_in, thing_num -> thing_out     stack channel; thing_out is qualified
//                                        by valid_lifo (pop) or valid_fifo2 (drain)
//   done_thing                           pulse on the last cycle of a pop group
//   done_fifo/done_lifo/done_fifo2       sticky completion flags
//   q_ovf/s_ovf/s_unf                    sticky error flags
module cipu_gen #(
   parameter int DW       = 8,
   parameter int QDEPTH   = 16,
   parameter int SDEPTH   = 32,
   parameter int NW       = 4,
   parameter int END_CODE = 'h24,
   parameter int SEP_CODE = 'h3B,
   parameter int LO_CODE  = 'h41,
   parameter int HI_CODE  = 'h5A
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ready_fifo,
   input  logic          ready_lifo,
   input  logic [DW-1:0] people_thing_in,
   input  logic [DW-1:0] thing_in,
   input  logic [NW-1:0] thing_num,
   output logic          valid_fifo,
   output logic          valid_lifo,
   output logic          valid_fifo2,
   output logic [DW-1:0] people_thing_out,
   output logic [DW-1:0] thing_out,
   output logic          done_thing,
   output logic          done_fifo,
   output logic          done_lifo,
   output logic          done_fifo2,
   output logic          q_ovf,
   output logic          s_ovf,
   output logic          s_unf
);

   localparam int QPW = $clog2(QDEPTH);
   localparam int SPW = $clog2(SDEPTH);

   localparam logic [DW-1:0] END_C = DW'(END_CODE);
   localparam logic [DW-1:0] SEP_C = DW'(SEP_CODE);
   localparam logic [DW-1:0] LO_C  = DW'(LO_CODE);
   localparam logic [DW-1:0] HI_C  = DW'(HI_CODE);

   localparam logic [QPW:0]   Q_ONE     = (QPW+1)'(1);
   localparam logic [QPW:0]   Q_FULL    = (QPW+1)'(QDEPTH);
   localparam logic [SPW:0]   S_ONE     = (SPW+1)'(1);
   localparam logic [SPW:0]   S_FULL    = (SPW+1)'(SDEPTH);
   localparam logic [SPW-1:0] S_IDX_ONE = SPW'(1);

   // ------------------------------------------------------------------
   // Queue channel
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {Q_IDLE, Q_RUN, Q_DRAIN, Q_DONE} q_state_t;

   q_state_t      q_state;
   q_state_t      q_nxt;
   logic [QPW:0]  q_wr;
   logic [QPW:0]  q_rd;
   logic [QPW:0]  q_cnt;
   logic          q_push_req;
   logic          q_push;
   logic          q_pop;
   logic          q_full;
   logic [DW-1:0] q_mem [QDEPTH];

   // Pointers carry one extra bit so full and empty are distinguishable.
   // The difference is the occupancy.
   assign q_cnt  = q_wr - q_rd;
   assign q_full = (q_cnt == Q_FULL);

   always_comb begin
      q_nxt      = q_state;
      q_push_req = 1'b0;
      q_pop      = 1'b0;
      case (q_state)
         Q_IDLE: begin
            if (ready_fifo) q_nxt = Q_RUN;
         end
         Q_RUN: begin
            q_pop = (q_cnt != '0);
            if (people_thing_in == END_C)
               q_nxt = Q_DRAIN;
            else if (people_thing_in >= LO_C && people_thing_in <= HI_C)
               q_push_req = 1'b1;
         end
         Q_DRAIN: begin
            q_pop = (q_cnt != '0);
            if (q_cnt == '0) q_nxt = Q_DONE;
         end
         Q_DONE: begin
            q_nxt = Q_DONE;
         end
         default: q_nxt = Q_IDLE;
      endcase
      // A pop in the same cycle frees the slot the push lands in.
      q_push = q_push_req && (!q_full || q_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_state          <= Q_IDLE;
         q_wr             <= '0;
         q_rd             <= '0;
         valid_fifo       <= 1'b0;
         people_thing_out <= '0;
         done_fifo        <= 1'b0;
         q_ovf            <= 1'b0;
      end else begin
         q_state    <= q_nxt;
         valid_fifo <= q_pop;
         done_fifo  <= (q_nxt == Q_DONE);
         if (q_push) q_wr <= q_wr + Q_ONE;
         if (q_pop) begin
            q_rd             <= q_rd + Q_ONE;
            people_thing_out <= q_mem[q_rd[QPW-1:0]];
         end
         if (q_push_req && !q_push) q_ovf <= 1'b1;
      end
   end

   // Storage is left uninitialised; only pointers define its contents.
   // When full, the read slot equals the write slot. The read sees the old
   // entry and the write lands after it.
   always_ff @(posedge clk) begin
      if (q_push) q_mem[q_wr[QPW-1:0]] <= people_thing_in;
   end

   // ------------------------------------------------------------------
   // Stack channel
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_POP, S_DRAIN, S_DONE} s_state_t;

   s_state_t       s_state;
   s_state_t       s_nxt;
   logic [SPW:0]   s_sp;        // occupancy; next free slot
   logic [SPW:0]   s_di;        // drain index, counts up from the bottom
   logic [SPW:0]   s_pc;        // pops remaining in the current group
   logic [SPW:0]   s_pc_load;
   logic [SPW-1:0] s_top_idx;
   logic [31:0]    tn_w;
   logic [31:0]    sp_w;
   logic           s_push;
   logic           s_sep;
   logic           s_end;
   logic           s_emit_top;
   logic           s_emit_bot;
   logic           s_ovf_set;
   logic           s_unf_set;
   logic [DW-1:0]  s_mem [SDEPTH];

   // A full stack has s_sp == SDEPTH with low bits zero. Subtracting one in
   // the narrow index width wraps to SDEPTH-1, which is the correct top slot.
   assign s_top_idx = s_sp[SPW-1:0] - S_IDX_ONE;
   assign tn_w      = 32'(thing_num);
   assign sp_w      = 32'(s_sp);

   always_comb begin
      s_nxt      = s_state;
      s_push     = 1'b0;
      s_sep      = 1'b0;
      s_end      = 1'b0;
      s_emit_top = 1'b0;
      s_emit_bot = 1'b0;
      s_ovf_set  = 1'b0;
      s_unf_set  = 1'b0;
      s_pc_load  = '0;
      case (s_state)
         S_IDLE: begin
            if (ready_lifo) s_nxt = S_RUN;
         end
         S_RUN: begin
            if (thing_in == END_C) begin
               s_end = 1'b1;
               // Nothing to drain: go straight to done.
               s_nxt = (s_sp == '0) ? S_DONE : S_DRAIN;
            end else if (thing_in == SEP_C) begin
               s_sep = 1'b1;
               s_nxt = S_POP;
               if (tn_w > sp_w) begin
                  s_unf_set = 1'b1;
                  s_pc_load = s_sp;
               end else begin
                  s_pc_load = tn_w[SPW:0];
               end
            end else if (s_sp == S_FULL) begin
               s_ovf_set = 1'b1;
            end else begin
               s_push = 1'b1;
            end
         end
         S_POP: begin
            // A zero count still spends one cycle here to produce done_thing.
            s_emit_top = (s_pc != '0);
            if (s_pc <= S_ONE) s_nxt = S_RUN;
         end
         S_DRAIN: begin
            if (s_di != s_sp) s_emit_bot = 1'b1;
            else              s_nxt      = S_DONE;
         end
         S_DONE: begin
            s_nxt = S_DONE;
         end
         default: s_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s_state     <= S_IDLE;
         s_sp        <= '0;
         s_di        <= '0;
         s_pc        <= '0;
         valid_lifo  <= 1'b0;
         valid_fifo2 <= 1'b0;
         thing_out   <= '0;
         done_thing  <= 1'b0;
         done_lifo   <= 1'b0;
         done_fifo2  <= 1'b0;
         s_ovf       <= 1'b0;
         s_unf       <= 1'b0;
      end else begin
         s_state     <= s_nxt;
         valid_lifo  <= s_emit_top;
         valid_fifo2 <= s_emit_bot;
         done_thing  <= (s_state == S_POP) && (s_pc <= S_ONE);
         done_fifo2  <= (s_nxt == S_DONE);
         if (s_push) s_sp <= s_sp + S_ONE;
         if (s_sep)  s_pc <= s_pc_load;
         if (s_end) begin
            s_di      <= '0;
            done_lifo <= 1'b1;
         end
         if (s_emit_top) begin
            s_sp      <= s_sp - S_ONE;
            s_pc      <= s_pc - S_ONE;
            thing_out <= s_mem[s_top_idx];
         end
         if (s_emit_bot) begin
            s_di      <= s_di + S_ONE;
            thing_out <= s_mem[s_di[SPW-1:0]];
         end
         if (s_ovf_set) s_ovf <= 1'b1;
         if (s_unf_set) s_unf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_push) s_mem[s_sp[SPW-1:0]] <= thing_in;
   end

endmodule

// File: tb/tb_cipu_gen.sv
// Purpose: exercises both channels of cipu_gen against a queue-based model,
//          plus literal expectations for the worked examples.
// Latency: model outputs are updated at each rising edge and compared at the
//          following falling edge.
// Backpressure: the stack source holds the separator until done_thing.
module tb_cipu_gen;
   localparam int QD = 4;
   localparam int SD = 4;
   localparam logic [7:0] END_C = 8'h24;
   localparam logic [7:0] SEP_C = 8'h3B;

   logic       clk;
   logic       rst;
   logic       ready_fifo;
   logic       ready_lifo;
   logic [7:0] people_thing_in;
   logic [7:0] thing_in;
   logic [3:0] thing_num;
   logic       valid_fifo, valid_lifo, valid_fifo2;
   logic [7:0] people_thing_out, thing_out;
   logic       done_thing, done_fifo, done_lifo, done_fifo2;
   logic       q_ovf, s_ovf, s_unf;

   cipu_gen #(.DW(8), .QDEPTH(QD), .SDEPTH(SD), .NW(4)) dut (
      .clk(clk), .rst(rst), .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
      .people_thing_in(people_thing_in), .thing_in(thing_in), .thing_num(thing_num),
      .valid_fifo(valid_fifo), .valid_lifo(valid_lifo), .valid_fifo2(valid_fifo2),
      .people_thing_out(people_thing_out), .thing_out(thing_out),
      .done_thing(done_thing), .done_fifo(done_fifo), .done_lifo(done_lifo),
      .done_fifo2(done_fifo2), .q_ovf(q_ovf), .s_ovf(s_ovf), .s_unf(s_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int mq_ph, ms_ph, ms_pc, m_pre;
   bit m_pop;
   byte unsigned mq[$];
   byte unsigned ms[$];
   logic e_vf, e_vl, e_vf2, e_dt, e_df, e_dl, e_df2, e_qovf, e_sovf, e_sunf;
   logic [7:0] e_pto, e_to;

   always @(posedge clk) begin
      if (!rst) begin
         mq_ph = 0; ms_ph = 0; ms_pc = 0;
         mq.delete(); ms.delete();
         e_vf = 0; e_vl = 0; e_vf2 = 0; e_dt = 0; e_df = 0; e_dl = 0; e_df2 = 0;
         e_qovf = 0; e_sovf = 0; e_sunf = 0; e_pto = 0; e_to = 0;
      end else begin
         // queue: pop the head if running and non-empty; push letters while running
         m_pre = mq.size();
         m_pop = (mq_ph == 1 || mq_ph == 2) && m_pre > 0;
         e_vf  = m_pop;
         if (m_pop) e_pto = mq.pop_front();
         case (mq_ph)
            0: if (ready_fifo) mq_ph = 1;
            1: begin
               if (people_thing_in == END_C) mq_ph = 2;
               else if (people_thing_in >= 8'h41 && people_thing_in <= 8'h5A) begin
                  if (m_pre < QD || m_pop) mq.push_back(people_thing_in);
                  else e_qovf = 1;
               end
            end
            2: if (m_pre == 0) mq_ph = 3;
            default: ;
         endcase
         e_df = (mq_ph == 3);

         // stack: back of the queue is the top, front is the oldest entry
         e_vl = 0; e_vf2 = 0; e_dt = 0;
         case (ms_ph)
            0: if (ready_lifo) ms_ph = 1;
            1: begin
               if (thing_in == END_C) begin
                  e_dl = 1;
                  ms_ph = (ms.size() == 0) ? 4 : 3;
               end else if (thing_in == SEP_C) begin
                  if (int'(thing_num) > ms.size()) begin e_sunf = 1; ms_pc = ms.size(); end
                  else ms_pc = int'(thing_num);
                  ms_ph = 2;
               end else if (ms.size() == SD) e_sovf = 1;
               else ms.push_back(thing_in);
            end
            2: begin
               if (ms_pc > 0) begin e_vl = 1; e_to = ms.pop_back(); ms_pc--; end
               if (ms_pc == 0) begin e_dt = 1; ms_ph = 1; end
            end
            3: begin
               if (ms.size() > 0) begin e_vf2 = 1; e_to = ms.pop_front(); end
               else ms_ph = 4;
            end
            default: ;
         endcase
         e_df2 = (ms_ph == 4);
      end
   end

   // ---------------- per-cycle compare and output logs ----------------
   byte unsigned lq_log[$], ll_log[$], lf_log[$];
   logic [8:0]   dt_log[$];

   always @(negedge clk) begin
      if (chk_on) begin
         check("valid_fifo", valid_fifo, e_vf);
         check("valid_lifo", valid_lifo, e_vl);
         check("valid_fifo2", valid_fifo2, e_vf2);
         check("done_thing", done_thing, e_dt);
         check("done_fifo", done_fifo, e_df);
         check("done_lifo", done_lifo, e_dl);
         check("done_fifo2", done_fifo2, e_df2);
         check("q_ovf", q_ovf, e_qovf);
         check("s_ovf", s_ovf, e_sovf);
         check("s_unf", s_unf, e_sunf);
         if (e_vf) check("people_thing_out", people_thing_out, e_pto);
         if (e_vl || e_vf2) check("thing_out", thing_out, e_to);
      end
      if (valid_fifo === 1'b1)  lq_log.push_back(people_thing_out);
      if (valid_lifo === 1'b1)  ll_log.push_back(thing_out);
      if (valid_fifo2 === 1'b1) lf_log.push_back(thing_out);
      if (done_thing === 1'b1)  dt_log.push_back({valid_lifo, thing_out});
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      lq_log.delete(); ll_log.delete(); lf_log.delete(); dt_log.delete();
   endtask

   task automatic do_reset();
      rst = 0; ready_fifo = 0; ready_lifo = 0;
      people_thing_in = 0; thing_in = 0; thing_num = 0;
      cyc(); cyc();
      rst = 1;
      chk_on = 1'b1;
   endtask

   task automatic check_zero(input string name);
      check({name, "_flags"}, {valid_fifo, valid_lifo, valid_fifo2, done_thing, done_fifo,
                               done_lifo, done_fifo2, q_ovf, s_ovf, s_unf}, 32'h0);
      check({name, "_data"}, {people_thing_out, thing_out}, 32'h0);
   endtask

   task automatic check_log(input string name, input byte unsigned got[$], input string exp);
      check({name, "_len"}, got.size(), exp.len());
      for (int i = 0; i < exp.len(); i++)
         if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
   endtask

   task automatic feed_q(input string s);
      for (int i = 0; i < s.len(); i++) begin people_thing_in = s[i]; cyc(); end
      people_thing_in = 0;
   endtask

   // Leaves thing_in unchanged on return so no stray character is pushed.
   task automatic feed_s(input string s);
      for (int i = 0; i < s.len(); i++) begin thing_in = s[i]; cyc(); end
   endtask

   task automatic stack_sep(input int n);
      thing_in  = SEP_C;
      thing_num = 4'(n);
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (e_dt) break;
      end
      check("sep_done_thing", done_thing, 1);
   endtask

   task automatic start_s();
      ready_lifo = 1; cyc(); ready_lifo = 0;
   endtask

   task automatic start_q();
      ready_fifo = 1; cyc(); ready_fifo = 0;
   endtask

   // ---------------- main sequence ----------------
   int r;
   bit hold;
   logic [7:0] tmp;

   initial begin
      rst = 0; ready_fifo = 0; ready_lifo = 0;
      people_thing_in = 0; thing_in = 0; thing_num = 0;

      do_reset();
      check_zero("reset_state");

      // queue: letters only, '1' dropped
      clear_logs(); start_q(); feed_q("A1B$"); repeat (6) cyc();
      check_log("q_a1b", lq_log, "AB");
      check("q_a1b_done", done_fifo, 1);

      // queue wrap-around with depth 4
      do_reset(); clear_logs(); start_q(); feed_q("ABCDEF$"); repeat (8) cyc();
      check_log("q_wrap", lq_log, "ABCDEF");
      check("q_wrap_ovf", q_ovf, 0);

      // stack: pop two then drain the rest
      do_reset(); clear_logs(); start_s();
      feed_s("ABC"); stack_sep(2); feed_s("$"); thing_in = 0; repeat (6) cyc();
      check_log("s_pop2", ll_log, "CB");
      check("s_pop2_dt_len", dt_log.size(), 1);
      if (dt_log.size() > 0) check("s_pop2_dt_val", dt_log[0], 9'h142);
      check_log("s_drain", lf_log, "A");
      check("s_done_lifo", done_lifo, 1);
      check("s_done_fifo2", done_fifo2, 1);

      // stack: underflow request, then end on an empty stack
      do_reset(); clear_logs(); start_s();
      feed_s("X"); stack_sep(5);
      check("s_unf_flag", s_unf, 1);
      feed_s("$"); thing_in = 0; repeat (4) cyc();
      check_log("s_unf_pop", ll_log, "X");
      check("s_unf_fifo2_len", lf_log.size(), 0);
      check("s_unf_done_fifo2", done_fifo2, 1);

      // stack: zero pop count and overflow at depth 4
      do_reset(); clear_logs(); start_s();
      feed_s("PQ"); stack_sep(0);
      check("s_zero_pops", ll_log.size(), 0);
      feed_s("RST"); feed_s("$"); thing_in = 0; repeat (8) cyc();
      check("s_ovf_flag", s_ovf, 1);
      check_log("s_ovf_drain", lf_log, "PQRS");

      // reset in the middle of a 3-entry drain, then a fresh restart
      do_reset(); clear_logs(); start_s();
      feed_s("XYZ$"); thing_in = 0;
      for (int i = 0; i < 10; i++) begin
         if (valid_fifo2) break;
         cyc();
      end
      check("mid_drain_started", valid_fifo2, 1);
      rst = 0; cyc(); rst = 1;
      check_zero("mid_drain_reset");
      clear_logs(); repeat (5) cyc();
      check("mid_drain_no_output", lf_log.size(), 0);
      start_s(); feed_s("AB"); stack_sep(1); feed_s("$"); thing_in = 0; repeat (6) cyc();
      check_log("restart_pop", ll_log, "B");
      check_log("restart_drain", lf_log, "A");

      // randomized traffic on both channels
      for (int ep = 0; ep < 10; ep++) begin
         do_reset();
         hold = 0;
         for (int c = 0; c < 200; c++) begin
            if (c == 100 && (ep % 2 == 1)) begin rst = 0; hold = 0; end
            else rst = 1;
            ready_fifo = ($urandom_range(0, 7) == 0);
            ready_lifo = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 99);
            if (r < 2)       people_thing_in = END_C;
            else if (r < 65) people_thing_in = 8'($urandom_range(8'h41, 8'h5A));
            else             people_thing_in = 8'($urandom_range(0, 255));
            if (hold && e_dt) hold = 0;
            if (!hold) begin
               r = $urandom_range(0, 99);
               if (r < 2) thing_in = END_C;
               else if (r < 16) begin
                  thing_in  = SEP_C;
                  thing_num = 4'($urandom_range(0, 6));
                  hold      = 1;
               end else begin
                  tmp = 8'($urandom_range(0, 255));
                  if (tmp == END_C || tmp == SEP_C) tmp = 8'h61;
                  thing_in = tmp;
               end
            end
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
